cycle_sequencer: RTL

- Multi-cycle control sequencer for the CPU. It drives the fetch/decode/execute timing that the PC, register file and datapath consume.
- Shares the CPU clock. Reset with the same asynchronous pulse that clears the PC and register file.
- Produces one-hot timing steps plus per-cycle control strobes from the latched instruction opcode.
- Also counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/opcode_classifier.sv | 35 +++
 rtl/cycle_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU multi-cycle control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // Width of the one-hot timing_step bus (T0..T7).
    localparam int TSTEP_W = 8;

    // Sequencer states. F0..E3 keep encodings 0..7 so they line up with T0..T7.
    typedef enum logic [3:0] {
        ST_F0   = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_D    = 4'd3,
        ST_E0   = 4'd4,
        ST_E1   = 4'd5,
        ST_E2   = 4'd6,
        ST_E3   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    // Opcode classes. Reserved opcodes fold into CL_NOP.
    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_ALU   = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STORE = 3'd3,
        CL_JMP   = 3'd4,
        CL_JZ    = 3'd5,
        CL_HALT  = 3'd6
    } opclass_t;

    // Per-cycle control strobes, packed in a fixed order.
    typedef struct packed {
        logic mar_load;
        logic mem_read;
        logic mem_write;
        logic ir_load;
        logic pc_inc;
        logic pc_load;
        logic alu_en;
        logic reg_write;
    } ctrl_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Number of execute cycles for a class (0 means retire straight from D).
    function automatic logic [1:0] class_exec_len(input opclass_t cls);
        case (cls)
            CL_ALU:   return 2'd1;
            CL_LOAD:  return 2'd3;
            CL_STORE: return 2'd2;
            CL_JMP:   return 2'd1;
            CL_JZ:    return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps a raw opcode to its class and execute length.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: opcode (in), op_class (out), exec_len (out, 0..3 execute cycles).
module opcode_classifier
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output opclass_t            op_class,
    output logic [1:0]          exec_len
);

    always_comb begin
        op_class = CL_NOP;
        if (opcode >= OPCODE_W'(1) && opcode <= OPCODE_W'(7)) begin
            op_class = CL_ALU;
        end else if (opcode == OPCODE_W'(OP_LOAD)) begin
            op_class = CL_LOAD;
        end else if (opcode == OPCODE_W'(OP_STORE)) begin
            op_class = CL_STORE;
        end else if (opcode == OPCODE_W'(OP_JMP)) begin
            op_class = CL_JMP;
        end else if (opcode == OPCODE_W'(OP_JZ)) begin
            op_class = CL_JZ;
        end else if (opcode == OPCODE_W'(OP_HALT)) begin
            op_class = CL_HALT;
        end
        // OP_NOP and the reserved codes keep the CL_NOP default.
    end

    assign exec_len = class_exec_len(op_class);

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with one-hot timing steps and a retired-instruction counter.
// Latency: strobes are combinational decodes of the current state; state advances one step per clock.
// Backpressure: none by default; with CYCLE_SEQUENCER_SINGLE_STEP_EN defined it parks in F0 after each
//   retirement until step_go is seen high on a clock edge.
// Ports: clock, sequencer_reset (async, active high), opcode, zero_flag, step_go -> timing_step,
//   mar_load, mem_read, mem_write, ir_load, pc_inc, pc_load, alu_en, reg_write, halted, instr_count.
module cycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ICNT_W   = 16
) (
    input  logic                clock,
    input  logic                sequencer_reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                step_go,
    output logic [TSTEP_W-1:0]  timing_step,
    output logic                mar_load,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                alu_en,
    output logic                reg_write,
    output logic                halted,
    output logic [ICNT_W-1:0]   instr_count
);

    state_t     state;
    opclass_t   cls_q;
    logic [1:0] len_q;
    opclass_t   cls_d;
    logic [1:0] len_d;
    logic       retire;
    ctrl_t      ctrl;

`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
    logic       step_wait;
`else
    // step_go has no function in this build.
    logic       unused_step_go;
    assign unused_step_go = step_go;
`endif

    // The opcode is only looked at while in D; E steps use the latched class.
    opcode_classifier #(
        .OPCODE_W (OPCODE_W)
    ) u_classifier (
        .opcode   (opcode),
        .op_class (cls_d),
        .exec_len (len_d)
    );

    // Last cycle of an instruction. HALT has zero execute length and so
    // counts as retiring when it leaves D.
    always_comb begin
        retire = 1'b0;
        case (state)
            ST_D:    retire = (len_d == 2'd0);
            ST_E0:   retire = (len_q == 2'd1);
            ST_E1:   retire = (len_q == 2'd2);
            ST_E2:   retire = 1'b1;
            ST_E3:   retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge sequencer_reset) begin
        if (sequencer_reset) begin
            state       <= ST_F0;
            cls_q       <= CL_NOP;
            len_q       <= 2'd0;
            instr_count <= '0;
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
            step_wait   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_F0: begin
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
                    // Leaving the wait costs one edge; the real F0 cycle
                    // (with mar_load) follows it.
                    if (step_wait) begin
                        if (step_go) begin
                            step_wait <= 1'b0;
                        end
                    end else begin
                        state <= ST_F1;
                    end
`else
                    state <= ST_F1;
`endif
                end
                ST_F1: state <= ST_F2;
                ST_F2: state <= ST_D;
                ST_D: begin
                    cls_q <= cls_d;
                    len_q <= len_d;
                    if (cls_d == CL_HALT) begin
                        state <= ST_HALT;
                    end else if (len_d == 2'd0) begin
                        state <= ST_F0;
                    end else begin
                        state <= ST_E0;
                    end
                end
                ST_E0:   state <= retire ? ST_F0 : ST_E1;
                ST_E1:   state <= retire ? ST_F0 : ST_E2;
                ST_E2:   state <= ST_F0;
                ST_E3:   state <= ST_F0;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_F0;
            endcase

            if (retire) begin
                instr_count <= instr_count + ICNT_W'(1);
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
                // A step_go already high at the retiring edge skips the wait.
                step_wait   <= ~step_go;
`endif
            end
        end
    end

    // Strobe decode; forced low while reset is held, since reset parks the
    // state in F0 which would otherwise show mar_load.
    always_comb begin
        ctrl = '0;
        if (!sequencer_reset) begin
            case (state)
                ST_F0: begin
`ifdef CYCLE_SEQUENCER_SINGLE_STEP_EN
                    ctrl.mar_load = ~step_wait;
`else
                    ctrl.mar_load = 1'b1;
`endif
                end
                ST_F1: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.pc_inc   = 1'b1;
                end
                ST_F2: ctrl.ir_load = 1'b1;
                ST_E0: begin
                    case (cls_q)
                        CL_ALU: begin
                            ctrl.alu_en    = 1'b1;
                            ctrl.reg_write = 1'b1;
                        end
                        CL_LOAD:  ctrl.mar_load = 1'b1;
                        CL_STORE: ctrl.mar_load = 1'b1;
                        CL_JMP:   ctrl.pc_load  = 1'b1;
                        CL_JZ:    ctrl.pc_load  = zero_flag;
                        default:  ;
                    endcase
                end
                ST_E1: begin
                    case (cls_q)
                        CL_LOAD:  ctrl.mem_read  = 1'b1;
                        CL_STORE: ctrl.mem_write = 1'b1;
                        default:  ;
                    endcase
                end
                ST_E2: begin
                    if (cls_q == CL_LOAD) begin
                        ctrl.reg_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        timing_step = '0;
        case (state)
            ST_F0:   timing_step = 8'b0000_0001;
            ST_F1:   timing_step = 8'b0000_0010;
            ST_F2:   timing_step = 8'b0000_0100;
            ST_D:    timing_step = 8'b0000_1000;
            ST_E0:   timing_step = 8'b0001_0000;
            ST_E1:   timing_step = 8'b0010_0000;
            ST_E2:   timing_step = 8'b0100_0000;
            ST_E3:   timing_step = 8'b1000_0000;
            default: timing_step = '0;
        endcase
    end

    assign mar_load  = ctrl.mar_load;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign ir_load   = ctrl.ir_load;
    assign pc_inc    = ctrl.pc_inc;
    assign pc_load   = ctrl.pc_load;
    assign alu_en    = ctrl.alu_en;
    assign reg_write = ctrl.reg_write;
    assign halted    = (state == ST_HALT);

endmodule
